// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the data-memory store-buffer subsystem.
// The entry struct is sized from DMEM_N / DMEM_AW, so a top-level override of
// N or AW must be matched here.
package dmem_pkg;

   localparam int DMEM_N      = 64;
   localparam int DMEM_AW     = 6;
   localparam int DMEM_DEPTH  = 4;
   localparam int DMEM_WR_LAT = 2;

   typedef struct packed {
      logic [DMEM_AW-1:0] index;
      logic [DMEM_N-1:0]  data;
   } sb_entry_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } commit_state_t;

endpackage

// File: rtl/sb_fifo.sv
// In-order store buffer: circular FIFO of {word index, data} with a per-entry
// valid vector and an associative lookup that reports the youngest matching
// entry. Build macro DMEM_SB_FWD_EN adds the forwarded-data output; without it
// only the hit flag is produced.
module sb_fifo
   import dmem_pkg::*;
#(
   parameter  int DEPTH = DMEM_DEPTH,
   localparam int PW    = $clog2(DEPTH),
   localparam int CNTW  = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  sb_entry_t          push_entry,
   input  logic               pop,
   input  logic [DMEM_AW-1:0] lookup_index,
   output sb_entry_t          head_entry,
   output logic [CNTW-1:0]    count,
   output logic               hit
`ifdef DMEM_SB_FWD_EN
   ,
   output logic [DMEM_N-1:0]  hit_data
`endif
);

   sb_entry_t        mem [DEPTH];
   logic [DEPTH-1:0] valid;
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;

   // Pointer, count and valid bookkeeping; a push into the slot being popped keeps it valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         valid <= '0;
      end else begin
         if (pop) begin
            head        <= head + PW'(1);
            valid[head] <= 1'b0;
         end
         if (push) begin
            tail        <= tail + PW'(1);
            valid[tail] <= 1'b1;
         end
         count <= count + CNTW'(push) - CNTW'(pop);
      end
   end

   // Entry payload storage; contents are qualified by the valid vector, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[tail] <= push_entry;
      end
   end

   assign head_entry = mem[head];

   // Walk oldest to youngest so the last matching entry seen is the youngest one.
   always_comb begin
      logic [PW-1:0] slot;
      slot = '0;
      hit  = 1'b0;
`ifdef DMEM_SB_FWD_EN
      hit_data = '0;
`endif
      for (int k = 0; k < DEPTH; k++) begin
         slot = head + PW'(k);
         if (valid[slot] && (mem[slot].index == lookup_index)) begin
            hit = 1'b1;
`ifdef DMEM_SB_FWD_EN
            hit_data = mem[slot].data;
`endif
         end
      end
   end

endmodule

// File: rtl/dmem_sb_ctrl.sv
// Data-memory subsystem behind the MEM stage: stores are posted into sb_fifo
// and drained by a commit FSM into a slow-write RAM; loads read the RAM
// combinationally. Build macro DMEM_SB_FWD_EN enables store-to-load forwarding;
// without it a load that matches a buffered store stalls until that store commits.
module dmem_sb_ctrl
   import dmem_pkg::*;
#(
   parameter  int N      = DMEM_N,
   parameter  int AW     = DMEM_AW,
   parameter  int DEPTH  = DMEM_DEPTH,
   parameter  int WR_LAT = DMEM_WR_LAT,
   localparam int CNTW   = $clog2(DEPTH) + 1,
   localparam int CW     = (WR_LAT > 1) ? $clog2(WR_LAT) : 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            DM_readEnable,
   input  logic            DM_writeEnable,
   input  logic [N-1:0]    DM_addr,
   input  logic [N-1:0]    DM_writeData,
   output logic [N-1:0]    DM_readData,
   output logic            mem_stall,
   output logic [CNTW-1:0] sb_count,
   output logic            sb_empty
);

   commit_state_t state;
   commit_state_t next_state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] next_cnt;
   logic          commit_done;

   logic [N-1:0]  ram [2**AW];

   logic [AW-1:0] word_idx;
   logic          store_ok;
   logic          push;
   logic          hit;
   sb_entry_t     head_entry;
   sb_entry_t     push_entry;
   logic          unused_addr_bits;
`ifdef DMEM_SB_FWD_EN
   logic [N-1:0]  hit_data;
`endif

   assign word_idx         = DM_addr[AW+2:3];
   assign unused_addr_bits = ^{DM_addr[N-1:AW+3], DM_addr[2:0]};

   // A full buffer can still take a store in the cycle its head commit pops.
   assign store_ok   = (sb_count < CNTW'(DEPTH)) || commit_done;
   assign push       = DM_writeEnable && store_ok;
   assign push_entry = '{index: word_idx, data: DM_writeData};
   assign sb_empty   = (sb_count == '0);

   sb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .push         (push),
      .push_entry   (push_entry),
      .pop          (commit_done),
      .lookup_index (word_idx),
      .head_entry   (head_entry),
      .count        (sb_count),
      .hit          (hit)
`ifdef DMEM_SB_FWD_EN
      ,
      .hit_data     (hit_data)
`endif
   );

   // Commit FSM state and write-latency counter; reset abandons any commit in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
      end
   end

   // Start a commit when work is queued and chain straight into the next one if entries remain.
   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      case (state)
         IDLE: begin
            if (sb_count != '0) begin
               next_state = BUSY;
               next_cnt   = CW'(WR_LAT - 1);
            end
         end
         BUSY: begin
            if (cnt != '0) begin
               next_cnt = cnt - CW'(1);
            end else if ((sb_count > CNTW'(1)) || push) begin
               next_cnt = CW'(WR_LAT - 1);
            end else begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
            next_cnt   = '0;
         end
      endcase
   end

   // The head commit completes on the last cycle of its write latency.
   always_comb begin
      commit_done = (state == BUSY) && (cnt == '0);
   end

   // Backing RAM write port, driven only by a completing commit.
   always_ff @(posedge clk) begin
      if (!reset && commit_done) begin
         ram[head_entry.index] <= head_entry.data;
      end
   end

   // Load data select and stall; a store with both enables set suppresses the load.
   always_comb begin
      DM_readData = '0;
      mem_stall   = 1'b0;
      if (DM_writeEnable) begin
         mem_stall = !store_ok;
      end else if (DM_readEnable) begin
`ifdef DMEM_SB_FWD_EN
         DM_readData = hit ? hit_data : ram[word_idx];
`else
         mem_stall   = hit;
         DM_readData = ram[word_idx];
`endif
      end
   end

endmodule

// File: tb/tb_dmem_sb_ctrl.sv
// Directed bench for dmem_sb_ctrl. Load expectations come from a word-level
// memory model (latest value stored per index), queued when the load is driven
// and compared when the DUT accepts it. Build macro DMEM_SB_FWD_EN selects the
// forwarding-specific expectations.
module tb_dmem_sb_ctrl;
   import dmem_pkg::*;

   localparam int N      = 64;
   localparam int AW     = 6;
   localparam int DEPTH  = 4;
   localparam int WR_LAT = 4;
   localparam int CNTW   = $clog2(DEPTH) + 1;
   localparam int BOUND  = 200;

   logic            clk = 1'b0;
   logic            reset;
   logic            DM_readEnable;
   logic            DM_writeEnable;
   logic [N-1:0]    DM_addr;
   logic [N-1:0]    DM_writeData;
   logic [N-1:0]    DM_readData;
   logic            mem_stall;
   logic [CNTW-1:0] sb_count;
   logic            sb_empty;

   int errors = 0;
   int checks = 0;
   int max_count = 0;
   int stalls;
   logic [N-1:0] model_mem [2**AW];
   logic [N-1:0] exp_q [$];
   logic [N-1:0] dropped;

   always #5 clk = ~clk;

   dmem_sb_ctrl #(
      .N      (N),
      .AW     (AW),
      .DEPTH  (DEPTH),
      .WR_LAT (WR_LAT)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .DM_readEnable  (DM_readEnable),
      .DM_writeEnable (DM_writeEnable),
      .DM_addr        (DM_addr),
      .DM_writeData   (DM_writeData),
      .DM_readData    (DM_readData),
      .mem_stall      (mem_stall),
      .sb_count       (sb_count),
      .sb_empty       (sb_empty)
   );

   // Track the highest occupancy ever seen.
   always @(negedge clk) begin
      if (int'(sb_count) > max_count) max_count = int'(sb_count);
   end

   function automatic logic [AW-1:0] idx(input logic [N-1:0] a);
      return a[AW+2:3];
   endfunction

   task automatic checkOutput(input string tag, input logic [N-1:0] observed, input logic [N-1:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      DM_readEnable  = 1'b0;
      DM_writeEnable = 1'b0;
      DM_addr        = '0;
      DM_writeData   = '0;
   endtask

   task automatic applyStimulus(input logic we, input logic re, input logic [N-1:0] addr, input logic [N-1:0] data);
      DM_writeEnable = we;
      DM_readEnable  = re;
      DM_addr        = addr;
      DM_writeData   = data;
      if (we && re) exp_q.push_back('0);
      else if (re) exp_q.push_back(model_mem[idx(addr)]);
   endtask

   // Present a store and hold it until accepted; returns 1ns after the accepting edge.
   task automatic doStore(input logic [N-1:0] addr, input logic [N-1:0] data);
      int waited = 0;
      applyStimulus(1'b1, 1'b0, addr, data);
      @(negedge clk);
      while (mem_stall && waited < BOUND) begin
         step();
         @(negedge clk);
         waited++;
      end
      checkOutput("store_accept", N'(mem_stall), N'(1'b0));
      model_mem[idx(addr)] = data;
      step();
      idle();
   endtask

   // Present a load, hold it through stalls, then compare against the queued expectation.
   task automatic doLoad(input logic [N-1:0] addr, output int stall_cycles);
      int waited = 0;
      applyStimulus(1'b0, 1'b1, addr, '0);
      @(negedge clk);
      while (mem_stall && waited < BOUND) begin
         step();
         @(negedge clk);
         waited++;
      end
      checkOutput("load_accept", N'(mem_stall), N'(1'b0));
      checkOutput("load_data", DM_readData, exp_q.pop_front());
      stall_cycles = waited;
      step();
      idle();
   endtask

   task automatic drain();
      int waited = 0;
      @(negedge clk);
      while (!sb_empty && waited < BOUND) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("drain", N'(sb_empty), N'(1'b1));
      step();
   endtask

   initial begin
      idle();
      reset = 1'b1;
      step();
      step();
      @(negedge clk);
      checkOutput("reset_count", N'(sb_count), '0);
      checkOutput("reset_empty", N'(sb_empty), N'(1'b1));
      checkOutput("reset_stall", N'(mem_stall), N'(1'b0));
      checkOutput("reset_rdata", DM_readData, '0);
      checkOutput("reset_state", N'(dut.state), N'(IDLE));
      step();
      reset = 1'b0;

      // Preload RAM[2] through the store path, then read it back from the RAM.
      doStore(64'h10, 64'hAB);
      drain();
      doLoad(64'h10, stalls);
      checkOutput("ram_load_stalls", N'(stalls), '0);
      checkOutput("ram_load_empty", N'(sb_empty), N'(1'b1));

      // Store then immediate load of the same word; RAM write lands at E0+WR_LAT+1.
      doStore(64'h18, 64'h55);
      applyStimulus(1'b0, 1'b1, 64'h18, '0);
      @(negedge clk);
`ifdef DMEM_SB_FWD_EN
      checkOutput("fwd_stall", N'(mem_stall), N'(1'b0));
      checkOutput("fwd_data", DM_readData, exp_q.pop_front());
`else
      checkOutput("match_stall", N'(mem_stall), N'(1'b1));
      dropped = exp_q.pop_front();
`endif
      checkOutput("fwd_count", N'(sb_count), N'(1));
      step();
      idle();
      repeat (WR_LAT - 1) step();
      checkOutput("ram_before_commit", N'(dut.ram[3] === 64'h55), N'(1'b0));
      step();
      checkOutput("ram_at_commit", dut.ram[3], 64'h55);
      checkOutput("empty_after_commit", N'(sb_empty), N'(1'b1));
      doLoad(64'h18, stalls);

      // Two stores to one word: the younger value wins.
      doStore(64'h20, 64'h1);
      doStore(64'h20, 64'h2);
      doLoad(64'h20, stalls);
`ifdef DMEM_SB_FWD_EN
      checkOutput("youngest_stalls", N'(stalls), '0);
`endif
      drain();
      checkOutput("ram4_after_drain", dut.ram[4], 64'h2);

      // Both enables: behaves as a store, read data forced to zero.
      applyStimulus(1'b1, 1'b1, 64'h28, 64'h77);
      @(negedge clk);
      checkOutput("both_en_data", DM_readData, exp_q.pop_front());
      checkOutput("both_en_stall", N'(mem_stall), N'(1'b0));
      model_mem[idx(64'h28)] = 64'h77;
      step();
      idle();
      drain();
      doLoad(64'h28, stalls);

      // Fill the buffer; the fifth store waits for the first commit and enters with it.
      for (int i = 0; i < DEPTH; i++) doStore(64'h40 + 64'(8 * i), 64'h100 + 64'(i));
      applyStimulus(1'b1, 1'b0, 64'h60, 64'h104);
      @(negedge clk);
      checkOutput("full_stall", N'(mem_stall), N'(1'b1));
      checkOutput("full_count", N'(sb_count), N'(DEPTH));
      step();
      @(negedge clk);
      checkOutput("full_accept_on_commit", N'(mem_stall), N'(1'b0));
      step();
      model_mem[idx(64'h60)] = 64'h104;
      idle();
      checkOutput("full_count_after", N'(sb_count), N'(DEPTH));
      drain();
      for (int i = 0; i <= DEPTH; i++) doLoad(64'h40 + 64'(8 * i), stalls);

      // Reset in the middle of a commit drops the pending store.
      doStore(64'h08, 64'h7);
      drain();
      doStore(64'h08, 64'h9);
      step();
      checkOutput("busy_before_reset", N'(dut.state), N'(BUSY));
      reset = 1'b1;
      step();
      @(negedge clk);
      checkOutput("midreset_count", N'(sb_count), '0);
      checkOutput("midreset_empty", N'(sb_empty), N'(1'b1));
      checkOutput("midreset_stall", N'(mem_stall), N'(1'b0));
      checkOutput("midreset_state", N'(dut.state), N'(IDLE));
      repeat (WR_LAT + 2) step();
      reset = 1'b0;
      repeat (WR_LAT + 2) step();
      model_mem[idx(64'h08)] = 64'h7;
      checkOutput("ram1_kept", dut.ram[1], 64'h7);
      doLoad(64'h08, stalls);

      // Load right behind a store to the same word.
      doStore(64'h30, 64'hC0FFEE);
      doLoad(64'h30, stalls);
`ifdef DMEM_SB_FWD_EN
      checkOutput("raw_stalls", N'(stalls), '0);
`else
      checkOutput("raw_stalls", N'(stalls), N'(WR_LAT + 1));
`endif

      // No request: outputs quiet.
      idle();
      @(negedge clk);
      checkOutput("noreq_rdata", DM_readData, '0);
      checkOutput("noreq_stall", N'(mem_stall), N'(1'b0));
      checkOutput("max_count_bound", N'(max_count > DEPTH), N'(1'b0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
